// File: rtl/pipeline_pkg.sv
// Shared constants and state encoding for the pipeline control slice.
package pipeline_pkg;

  localparam int unsigned RegAddrWidthDefault = 3;
  localparam int unsigned WordWidth           = 16;

  // 2'b10 is unused and decodes as halt.
  typedef enum logic [1:0] {
    StHalt  = 2'b00,
    StRun   = 2'b01,
    StDrain = 2'b11
  } state_e;

endpackage

// File: rtl/pipeline_controller_if.sv
// Control bundle between the pipeline controller and the fetch stage / pipeline registers.
interface pipeline_controller_if
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = RegAddrWidthDefault
) ();

  logic                      exec;
  logic                      id_valid;
  logic                      id_uses_rs;
  logic                      id_uses_rt;
  logic [REG_ADDR_WIDTH-1:0] id_rs;
  logic [REG_ADDR_WIDTH-1:0] id_rt;
  logic                      id_halt;
  logic                      ex_valid;
  logic                      ex_is_load;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_branch_taken;
  logic [WordWidth-1:0]      ex_branch_target;

  logic                      op_pc_write;
  logic                      op_branch;
  logic                      op_cc_write;
  logic [WordWidth-1:0]      branch_address;
  logic                      if_id_write;
  logic                      flush_if_id;
  logic                      flush_id_ex;
  logic                      running;
  logic [WordWidth-1:0]      stall_count;

  // Controller side.
  modport master (
    input  exec, id_valid, id_uses_rs, id_uses_rt, id_rs, id_rt, id_halt,
    input  ex_valid, ex_is_load, ex_rd, ex_branch_taken, ex_branch_target,
    output op_pc_write, op_branch, op_cc_write, branch_address,
    output if_id_write, flush_if_id, flush_id_ex, running, stall_count
  );

  // Datapath side.
  modport slave (
    output exec, id_valid, id_uses_rs, id_uses_rt, id_rs, id_rt, id_halt,
    output ex_valid, ex_is_load, ex_rd, ex_branch_taken, ex_branch_target,
    input  op_pc_write, op_branch, op_cc_write, branch_address,
    input  if_id_write, flush_if_id, flush_id_ex, running, stall_count
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard: ID reads a register that the load currently in EX will write.
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = RegAddrWidthDefault
) (
  input  logic                      id_valid,
  input  logic                      id_uses_rs,
  input  logic                      id_uses_rt,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      ex_valid,
  input  logic                      ex_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match = id_uses_rs && (id_rs == ex_rd);
  assign rt_match = id_uses_rt && (id_rt == ex_rd);
  assign hazard   = id_valid && ex_valid && ex_is_load && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_controller.sv
// Fetch-stage sequencing: start/halt, load-use bubbles, branch flushes and halt drain.
module pipeline_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = RegAddrWidthDefault,
  parameter int unsigned DRAIN_CYCLES   = 3
) (
  input logic                   clock,
  input logic                   reset,
  pipeline_controller_if.master ctrl
);

  localparam int unsigned CntWidth = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CntWidth-1:0] DrainLoad = CntWidth'(DRAIN_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [WordWidth-1:0] stall_q;

  logic hazard;
  logic running;
  logic pc_write, branch, cc_write, ifid_write, flush_ifid, flush_idex;
  logic stall_inc;

  hazard_detect #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_hazard_detect (
    .id_valid   (ctrl.id_valid),
    .id_uses_rs (ctrl.id_uses_rs),
    .id_uses_rt (ctrl.id_uses_rt),
    .id_rs      (ctrl.id_rs),
    .id_rt      (ctrl.id_rt),
    .ex_valid   (ctrl.ex_valid),
    .ex_is_load (ctrl.ex_is_load),
    .ex_rd      (ctrl.ex_rd),
    .hazard     (hazard)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b0;
    branch     = 1'b0;
    cc_write   = 1'b0;
    ifid_write = 1'b0;
    flush_ifid = 1'b1;
    flush_idex = 1'b1;
    case (state_q)
      StRun: begin
        pc_write   = 1'b1;
        cc_write   = 1'b1;
        ifid_write = 1'b1;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        // A taken branch squashes ID, so its hazard or halt never counts.
        if (ctrl.ex_branch_taken) begin
          branch     = 1'b1;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (hazard) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          flush_idex = 1'b1;
        end else if (ctrl.id_valid && ctrl.id_halt) begin
          pc_write   = 1'b0;
          flush_ifid = 1'b1;
          cnt_d      = DrainLoad;
          state_d    = StDrain;
        end
      end
      StDrain: begin
        cc_write   = 1'b1;
        ifid_write = 1'b1;
        flush_idex = 1'b0;
        if (cnt_q == '0) begin
          state_d = StHalt;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (ctrl.exec) begin
          state_d = StRun;
        end
      end
    endcase
  end

  assign running   = (state_q == StRun) || (state_q == StDrain);
  assign stall_inc = running && (!pc_write || flush_ifid);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StHalt;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_inc && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign ctrl.op_pc_write    = pc_write;
  assign ctrl.op_branch      = branch;
  assign ctrl.op_cc_write    = cc_write;
  assign ctrl.if_id_write    = ifid_write;
  assign ctrl.flush_if_id    = flush_ifid;
  assign ctrl.flush_id_ex    = flush_idex;
  assign ctrl.branch_address = ctrl.ex_branch_target;
  assign ctrl.running        = running;
  assign ctrl.stall_count    = stall_q;

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Sequencing controller for the simple pipeline's fetch stage and pipeline registers. Produces the fetch stage's `op_pc_write`, `op_branch`, `branch_address` and `op_cc_write` controls, and the IF/ID and ID/EX hold/flush strobes. Covers start/halt sequencing, load-use stalls, taken-branch flushes and draining the pipeline on a halt instruction. Sits beside the fetch stage; all hazard information comes from the ID and EX pipeline registers.

## Interface
- `REG_ADDR_WIDTH`, 3: register-number width.
- `DRAIN_CYCLES`, 3: cycles, after halt leaves ID, until the pipeline is empty (≥1).
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low.
- `exec`  in  1  start/resume pulse; ignored outside HALT.
- `id_valid`, `id_uses_rs`, `id_uses_rt`  in  1 each  ID-stage instruction valid / reads rs / reads rt.
- `id_rs`, `id_rt`  in  REG_ADDR_WIDTH  ID-stage source registers.
- `id_halt`  in  1  ID-stage instruction is HLT.
- `ex_valid`, `ex_is_load`  in  1 each  EX-stage instruction valid / is LD.
- `ex_rd`  in  REG_ADDR_WIDTH  EX-stage destination register.
- `ex_branch_taken`  in  1  branch resolved taken in EX.
- `ex_branch_target`  in  16  resolved branch target.
- `op_pc_write`, `op_branch`, `op_cc_write`  out  1 each  fetch-stage controls.
- `branch_address`  out  16  equals `ex_branch_target` (pass-through).
- `if_id_write`  out  1  IF/ID register load enable (0 = hold).
- `flush_if_id`, `flush_id_ex`  out  1 each  load a NOP into that register at the next edge.
- `running`  out  1  state ≠ HALT.
- `stall_count`  out  16  cycles lost to stalls, drains and flushes.

## Operation
- The state register is 2 bits: HALT=00, RUN=01, DRAIN=11 (10 unused and decodes as HALT). All outputs are Mealy: combinational from state and current inputs.
- HALT:
  - Outputs: op_pc_write=0, op_branch=0, op_cc_write=0, if_id_write=0, flush_if_id=1, flush_id_ex=1.
  - Transition: exec=1 → RUN.
- RUN:
  - Defaults: op_pc_write=1, if_id_write=1, op_cc_write=1, flushes 0.
  - Hazard is defined as id_valid & ex_valid & ex_is_load & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
  - Priority 1, ex_branch_taken: op_branch=1, op_pc_write=1, flush_if_id=1, flush_id_ex=1. Any hazard or id_halt in this cycle is discarded, because that instruction is squashed.
  - Priority 2, hazard: op_pc_write=0, if_id_write=0, flush_id_ex=1 (one bubble). State stays RUN.
  - Priority 3, id_valid & id_halt: op_pc_write=0, flush_if_id=1. Load the drain counter with DRAIN_CYCLES−1 and go to DRAIN.
- DRAIN:
  - Outputs: op_pc_write=0, if_id_write=1, flush_if_id=1, op_cc_write=1. ex_branch_taken is ignored.
  - The counter decrements each cycle; at counter==0 go to HALT.
- stall_count:
  - Increments by one in every non-HALT cycle where op_pc_write=0 or flush_if_id=1.
  - Saturates at 16'hFFFF and clears only on reset.
- branch_address is always ex_branch_target, whatever the state.

## Timing
- On reset (reset=0 at an edge): state=HALT, drain counter=0, stall_count=0. Outputs then read op_pc_write=0, op_branch=0, op_cc_write=0, if_id_write=0, flush_if_id=1, flush_id_ex=1, running=0.
- Reset mid-operation (RUN or DRAIN) behaves identically: HALT at the next edge, with no drain.
- Start latency: exec high in cycle n gives RUN in cycle n+1. The first PC increment happens at the end of n+1, and the clock counter first counts in n+1.
- Load-use stall costs exactly 1 cycle. In the following cycle the load has left EX, so the hazard clears automatically.
- Taken branch: the PC loads the target at the edge ending the resolving cycle, and 2 slots are squashed.
- Halt: id_halt accepted in cycle n gives DRAIN in cycles n+1 … n+DRAIN_CYCLES and HALT in cycle n+DRAIN_CYCLES+1. op_cc_write falls in that cycle.
- exec asserted in RUN or DRAIN has no effect.

## Structure
- Package `pipeline_pkg` holds:
  - the state encoding constants (HALT, RUN, DRAIN);
  - the REG_ADDR_WIDTH default;
  - the 16-bit word width constant shared with the fetch stage.
- Sub-module `hazard_detect` is purely combinational: the load-use comparison, with output `hazard`.
- The controller itself holds the FSM, drain counter, stall counter and output decode.

## Test plan
- Reset then exec: reset low 2 cycles, exec pulse in cycle 3 → running=1 and op_pc_write=1 from cycle 4; op_cc_write=0 before cycle 4.
- Load-use: ex_is_load=1, ex_rd=3, id_rs=3, id_uses_rs=1 for one cycle → op_pc_write=0, if_id_write=0, flush_id_ex=1 for that cycle only; stall_count +1.
- Branch beats hazard: ex_branch_taken=1, ex_branch_target=16'h0040, with the hazard also true → op_branch=1, op_pc_write=1, both flushes=1, branch_address=16'h0040.
- Halt drain: id_halt=1 with DRAIN_CYCLES=3 → op_pc_write=0 for 4 cycles, then running=0 and op_cc_write=0; stall_count +4.
- Reset in DRAIN: reset=0 in the second drain cycle → HALT next cycle, stall_count=0, exec then restarts normally.
- Ignored exec: exec pulses during RUN → no state change, no output glitch.
